// File: rtl/int_axi4l_master.sv
// int_axi4l_master: bridges the internal register-access initiator interface
// onto an AXI4-Lite master port. One transaction in flight at a time; a write
// and a read presented together are run back to back, write first.
module int_axi4l_master #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // internal initiator side
    input  logic [ADDR_WIDTH-1:0]     int_addr,
    input  logic [DATA_WIDTH-1:0]     int_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   int_wr_strb,
    input  logic                      int_wr_en,
    input  logic                      int_rd_en,
    output logic                      int_wr_ack,
    output logic                      int_wr_err,
    output logic                      int_rd_ack,
    output logic                      int_rd_err,
    output logic [DATA_WIDTH-1:0]     int_rd_data,
    output logic                      int_busy,
    // AXI4-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    // AXI4-Lite read address / data
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4
    } state_e;

    // SLVERR (2'b10) and DECERR (2'b11) are errors; OKAY/EXOKAY are not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == 2'b10) || (resp == 2'b11);
    endfunction

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,     wstrb_d;
    logic                    awvalid_q,   awvalid_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    bready_q,    bready_d;
    logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
    logic                    arvalid_q,   arvalid_d;
    logic                    rready_q,    rready_d;
    logic                    wr_ack_q,    wr_ack_d;
    logic                    wr_err_q,    wr_err_d;
    logic                    rd_ack_q,    rd_ack_d;
    logic                    rd_err_q,    rd_err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,   rd_data_d;
    logic                    busy_q,      busy_d;
    logic                    pend_q,      pend_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        wr_ack_d    = 1'b0;
        wr_err_d    = 1'b0;
        rd_ack_d    = 1'b0;
        rd_err_d    = 1'b0;
        rd_data_d   = rd_data_q;
        busy_d      = busy_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (int_wr_en) begin
                    awaddr_d  = int_addr;
                    wdata_d   = int_wr_data;
                    wstrb_d   = int_wr_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_WR_AW_W;
                    // A simultaneous read is remembered and issued after the write.
                    if (int_rd_en) begin
                        pend_d      = 1'b1;
                        pend_addr_d = int_addr;
                    end else begin
                        pend_d      = 1'b0;
                    end
                end else if (int_rd_en) begin
                    araddr_d  = int_addr;
                    arvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_RD_AR;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_WR_AW_W: begin
                // Each channel retires on its own handshake, in any order.
                awvalid_d = awvalid_q & ~m_axi_awready;
                wvalid_d  = wvalid_q & ~m_axi_wready;
                if ((~awvalid_q | m_axi_awready) & (~wvalid_q | m_axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_B;
                end else begin
                    state_d  = ST_WR_AW_W;
                end
            end

            ST_WR_B: begin
                if (m_axi_bvalid & bready_q) begin
                    bready_d = 1'b0;
                    wr_ack_d = 1'b1;
                    wr_err_d = resp_is_err(m_axi_bresp);
                    if (pend_q) begin
                        // Chain straight into the deferred read; stay busy.
                        araddr_d  = pend_addr_q;
                        arvalid_d = 1'b1;
                        pend_d    = 1'b0;
                        state_d   = ST_RD_AR;
                    end else begin
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WR_B;
                end
            end

            ST_RD_AR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_R;
                end else begin
                    state_d   = ST_RD_AR;
                end
            end

            ST_RD_R: begin
                if (m_axi_rvalid & rready_q) begin
                    rready_d  = 1'b0;
                    rd_data_d = m_axi_rdata;
                    rd_ack_d  = 1'b1;
                    rd_err_d  = resp_is_err(m_axi_rresp);
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_RD_R;
                end
            end

            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                busy_d    = 1'b0;
                pend_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            rd_ack_q    <= rd_ack_d;
            rd_err_q    <= rd_err_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign int_wr_ack    = wr_ack_q;
    assign int_wr_err    = wr_err_q;
    assign int_rd_ack    = rd_ack_q;
    assign int_rd_err    = rd_err_q;
    assign int_rd_data   = rd_data_q;
    assign int_busy      = busy_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = PROT;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = PROT;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: doc/int_axi4l_master.md
Name: int_axi4l_master
Overview:
Bridges the team's internal register-access interface (initiator side) onto an AXI4-Lite master port. It is the counterpart of the AXI4-Lite slave-to-internal bridge and lets internal logic (sequencers, DMA-less config engines) drive AXI4-Lite peripherals. One transaction is outstanding at a time. A write and a read presented in the same cycle are serialised, write first.
Parameters:
ADDR_WIDTH, 10, address width of internal and AXI buses
DATA_WIDTH, 32, data width; must be 32 or 64
PROT, 3'b000, constant driven on m_axi_awprot and m_axi_arprot
Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
int_addr  in  ADDR_WIDTH  request address, sampled when int_wr_en or int_rd_en is high
int_wr_data  in  DATA_WIDTH  write data, sampled with int_wr_en
int_wr_strb  in  DATA_WIDTH/8  write byte strobes, sampled with int_wr_en
int_wr_en  in  1  write request pulse
int_rd_en  in  1  read request pulse
int_wr_ack  out  1  one-cycle pulse: write response received
int_wr_err  out  1  valid with int_wr_ack; 1 = SLVERR/DECERR
int_rd_ack  out  1  one-cycle pulse: read data returned
int_rd_err  out  1  valid with int_rd_ack; 1 = SLVERR/DECERR
int_rd_data  out  DATA_WIDTH  read data; held from int_rd_ack until the next int_rd_ack
int_busy  out  1  high while a transaction is accepted and not yet acknowledged
m_axi_awaddr  out  ADDR_WIDTH  write address
m_axi_awprot  out  3  = PROT
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_WIDTH  write data
m_axi_wstrb  out  DATA_WIDTH/8  write strobes
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  ADDR_WIDTH  read address
m_axi_arprot  out  3  = PROT
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready
Behaviour:
- Reset: every registered output is 0 (valids, readys, acks, errs, int_rd_data, int_busy, addresses, data). FSM = IDLE, pending-read flag cleared. Reset mid-transaction abandons it: no ack is issued, and valids drop at the reset edge.
- FSM: IDLE, WR_AW_W, WR_B, RD_AR, RD_R. All AXI outputs are registered.
- IDLE with int_wr_en at cycle 0: latch addr/data/strb. At cycle 1, awvalid=wvalid=1, int_busy=1, state WR_AW_W. If int_rd_en is also high at cycle 0, latch int_addr as the pending read address and set the pending flag.
- IDLE with int_rd_en only at cycle 0: araddr latched, arvalid=1 at cycle 1, state RD_AR.
- WR_AW_W: awvalid and wvalid each drop independently on their own handshake, in either order or together. Once both have completed, move to WR_B with bready=1 in the next cycle. Payload is stable while valid is high.
- WR_B: on the bvalid&bready cycle, bready drops. The next cycle gives int_wr_ack=1 and int_wr_err=bresp[1]. With no pending read: state IDLE and int_busy=0 in that ack cycle. With a pending read: go directly to RD_AR (arvalid=1 in the ack cycle), int_busy stays 1, and the pending flag clears.
- RD_AR: arvalid drops on arready, then RD_R with rready=1. On rvalid&rready: int_rd_data<=rdata, and the next cycle gives int_rd_ack=1, int_rd_err=rresp[1], state IDLE, int_busy=0.
- A new request may be presented in the ack cycle and is accepted. int_wr_en/int_rd_en while int_busy=1 is a protocol violation: the request is ignored and state is unchanged.
- Minimum latency with ready slaves: request cycle 0, valid at cycle 1, handshake at cycle 1, response at cycle 2, ack at cycle 3.
Test Plan:
- Write 0x004 / 0xDEADBEEF / strb 0xF; slave has awready=wready=1 and bvalid 1 cycle later with bresp=00 -> awaddr=0x004, wdata=0xDEADBEEF, one int_wr_ack pulse with int_wr_err=0, int_busy low in the ack cycle.
- Write where wready arrives 3 cycles before awready -> wvalid drops first, awvalid holds with a stable address, bready asserts only after both handshakes, exactly one int_wr_ack.
- Read 0x010; slave returns rdata 0x12345678 with rresp=10 after 4 wait cycles -> int_rd_ack pulse, int_rd_err=1, int_rd_data=0x12345678 held afterwards.
- int_wr_en and int_rd_en in the same cycle (addr 0x020) -> write completes and int_wr_ack pulses with arvalid=1 in the same cycle, then int_rd_ack; int_busy stays continuously high until the read ack.
- int_rd_en pulsed while busy -> no AXI read is issued and no extra ack appears. A new request in the ack cycle is accepted, with its valid rising the next cycle.
- aresetn low while awvalid=1 and awready held 0 -> next edge: all valids, int_busy and acks are 0. A write issued after reset completes normally.
